// File: rtl/anim_pkg.sv
// Shared encodings for the fighter animation sequencer.
// State values are visible to the sprite mapper, so keep them fixed.
package anim_pkg;
    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 4'd0,
        S_MOVE = 4'd1,
        S_JUMP = 4'd2,
        S_ATK1 = 4'd3,
        S_HIT  = 4'd5
    } anim_state_t;
endpackage

// File: rtl/anim_frame_counter.sv
// Hold/frame counter shared by all timed animation states.
// Loop mode wraps the frame; one-shot mode saturates on the last frame.
module anim_frame_counter #(
    parameter int FRAME_W = 6,
    parameter int HOLD_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               restart,
    input  logic [FRAME_W:0]   frames,
    input  logic [HOLD_W:0]    hold,
    input  logic               loop_mode,
    output logic [FRAME_W-1:0] frame,
    output logic               done
);
    localparam int FC_W = FRAME_W + 1;
    localparam int HC_W = HOLD_W + 1;

    logic [HOLD_W-1:0] hold_q;
    logic              hold_end;
    logic              at_last;
    logic              next_last;

    assign hold_end  = ({1'b0, hold_q} == hold - HC_W'(1));
    assign at_last   = ({1'b0, frame} == frames - FC_W'(1));
    assign next_last = ({1'b0, frame} + FC_W'(1) == frames - FC_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            frame  <= '0;
            done   <= 1'b0;
        end else if (!tick) begin
            done <= 1'b0;
        end else if (restart) begin
            hold_q <= '0;
            frame  <= '0;
            done   <= 1'b0;
        end else if (hold_end) begin
            hold_q <= '0;
            if (at_last) begin
                // A saturated one-shot stays silent on later advances
                frame <= loop_mode ? '0 : frame;
                done  <= loop_mode;
            end else begin
                frame <= frame + FRAME_W'(1);
                done  <= !loop_mode && next_last;
            end
        end else begin
            hold_q <= hold_q + HOLD_W'(1);
            done   <= 1'b0;
        end
    end
endmodule

// File: rtl/player_anim_sequencer.sv
// Turns one fighter's gameplay flags into animation state and frame index.
// Attack frames pass through (clamped); other states are timed locally.
module player_anim_sequencer
    import anim_pkg::*;
#(
    parameter int FRAME_W     = 6,
    parameter int HOLD_W      = 4,
    parameter int IDLE_FRAMES = 4,
    parameter int IDLE_HOLD   = 4,
    parameter int WALK_FRAMES = 8,
    parameter int WALK_HOLD   = 2,
    parameter int JUMP_FRAMES = 6,
    parameter int JUMP_HOLD   = 3,
    parameter int HIT_FRAMES  = 4,
    parameter int HIT_HOLD    = 3,
    parameter int ATK_FRAMES  = 18
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               SCEN,
    input  logic               hitstun_active,
    input  logic               attack_active,
    input  logic [FRAME_W-1:0] attack_frame,
    input  logic               move_active,
    input  logic               jump_active,
    output logic [STATE_W-1:0] anim_state,
    output logic [FRAME_W-1:0] anim_frame,
    output logic               anim_done,
    output logic               state_changed
);
    localparam int FC_W   = FRAME_W + 1;
    localparam int HC_W   = HOLD_W + 1;
    localparam int F_MAX  = 2 ** FRAME_W;
    localparam int H_MAX  = 2 ** HOLD_W;

    localparam bit CFG_OK =
        IDLE_FRAMES >= 1 && IDLE_FRAMES <= F_MAX &&
        WALK_FRAMES >= 1 && WALK_FRAMES <= F_MAX &&
        JUMP_FRAMES >= 1 && JUMP_FRAMES <= F_MAX &&
        HIT_FRAMES  >= 1 && HIT_FRAMES  <= F_MAX &&
        ATK_FRAMES  >= 1 && ATK_FRAMES  <= F_MAX &&
        IDLE_HOLD   >= 1 && IDLE_HOLD   <= H_MAX &&
        WALK_HOLD   >= 1 && WALK_HOLD   <= H_MAX &&
        JUMP_HOLD   >= 1 && JUMP_HOLD   <= H_MAX &&
        HIT_HOLD    >= 1 && HIT_HOLD    <= H_MAX;

    if (!CFG_OK) begin : g_bad_cfg
        $error("player_anim_sequencer: frame/hold parameter out of range");
    end

    localparam logic [FRAME_W-1:0] ATK_MAX = FRAME_W'(ATK_FRAMES - 1);

    anim_state_t        state_q;
    anim_state_t        target;
    logic [FRAME_W-1:0] atk_q;
    logic [FRAME_W-1:0] atk_clamp;
    logic [FRAME_W-1:0] cnt_frame;
    logic [FC_W-1:0]    frames_sel;
    logic [HC_W-1:0]    hold_sel;
    logic               loop_sel;
    logic               restart;

    always_comb begin
        target = S_IDLE;
        if (hitstun_active)     target = S_HIT;
        else if (attack_active) target = S_ATK1;
        else if (jump_active)   target = S_JUMP;
        else if (move_active)   target = S_MOVE;
    end

    assign atk_clamp = (attack_frame > ATK_MAX) ? ATK_MAX : attack_frame;

    always_comb begin
        frames_sel = FC_W'(IDLE_FRAMES);
        hold_sel   = HC_W'(IDLE_HOLD);
        loop_sel   = 1'b1;
        unique case (target)
            S_MOVE: begin
                frames_sel = FC_W'(WALK_FRAMES);
                hold_sel   = HC_W'(WALK_HOLD);
            end
            S_JUMP: begin
                frames_sel = FC_W'(JUMP_FRAMES);
                hold_sel   = HC_W'(JUMP_HOLD);
                loop_sel   = 1'b0;
            end
            S_HIT: begin
                frames_sel = FC_W'(HIT_FRAMES);
                hold_sel   = HC_W'(HIT_HOLD);
                loop_sel   = 1'b0;
            end
            default: ;
        endcase
    end

    // Attack keeps the counter parked at zero so it never reports done
    assign restart = (target != state_q) || (target == S_ATK1);

    anim_frame_counter #(
        .FRAME_W (FRAME_W),
        .HOLD_W  (HOLD_W)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .tick      (SCEN),
        .restart   (restart),
        .frames    (frames_sel),
        .hold      (hold_sel),
        .loop_mode (loop_sel),
        .frame     (cnt_frame),
        .done      (anim_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            atk_q         <= '0;
            state_changed <= 1'b0;
        end else if (SCEN) begin
            state_q       <= target;
            state_changed <= (target != state_q);
            if (target == S_ATK1) atk_q <= atk_clamp;
        end else begin
            state_changed <= 1'b0;
        end
    end

    assign anim_state = state_q;
    assign anim_frame = (state_q == S_ATK1) ? atk_q : cnt_frame;
endmodule

// File: doc/player_anim_sequencer.md
# player_anim_sequencer

Parametrised animation sequencer that turns the gameplay flags of one fighter into an animation state and frame index. It sits between the resolver, attack and move modules and the sprite mapper. Every state has its own frame count and hold time (SCEN ticks per frame) and runs in loop or one-shot mode. It adds multi-frame hit and jump animations, an idle loop, and frame-complete and state-change pulses.

## Interface
Parameters:
- FRAME_W, 6: width of frame index.
- HOLD_W, 4: width of hold counter.
- IDLE_FRAMES, 4; IDLE_HOLD, 4: idle loop length and ticks per frame.
- WALK_FRAMES, 8; WALK_HOLD, 2: walk loop.
- JUMP_FRAMES, 6; JUMP_HOLD, 3: jump, one-shot.
- HIT_FRAMES, 4; HIT_HOLD, 3: hit, one-shot.
- ATK_FRAMES, 18: attack frame clamp limit.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- SCEN  in  1  animation tick enable. State updates only on cycles with SCEN=1.
- hitstun_active  in  1  from resolver.
- attack_active  in  1  from attack module.
- attack_frame  in  FRAME_W  attack frame from attack module.
- move_active  in  1  from move module.
- jump_active  in  1  from move module.
- anim_state  out  4  IDLE=0, MOVE=1, JUMP=2, ATK1=3, HIT=5.
- anim_frame  out  FRAME_W  frame index for sprite mapper.
- anim_done  out  1  one-clk pulse: a loop wrapped, or a one-shot reached its last frame.
- state_changed  out  1  one-clk pulse when anim_state changes.

## Operation
- Target state is picked by priority: HIT > ATK1 > JUMP > MOVE > IDLE.
- On an SCEN cycle where the target differs from anim_state:
  - anim_state takes the target.
  - The frame counter and the hold counter both go to 0.
  - anim_frame=0, except ATK1, which uses the clamped attack_frame.
  - state_changed=1.
- On an SCEN cycle where the target equals anim_state, for IDLE, MOVE, JUMP and HIT:
  - The hold counter increments.
  - When hold == HOLD-1: the hold counter goes to 0 and the frame advances.
  - Loop states (IDLE, MOVE): frame wraps from FRAMES-1 to 0, and anim_done pulses on the wrap.
  - One-shot states (JUMP, HIT): frame saturates at FRAMES-1. anim_done pulses once, on the cycle the frame first reaches FRAMES-1, and never again while held.
- ATK1 is pass-through:
  - anim_frame = min(attack_frame, ATK_FRAMES-1) every SCEN cycle.
  - The hold counter is unused and held at 0.
  - anim_done is never asserted.
- HOLD=1 means the frame advances on every SCEN tick. FRAMES=1 means the frame stays at 0.
  - For a loop with FRAMES=1, anim_done pulses on every advance.
  - For a one-shot with FRAMES=1, anim_done never pulses (entry already lands on the last frame).
- A non-SCEN cycle holds every register. anim_done and state_changed are 0 on all non-SCEN cycles.
- Elaboration-time checks: every FRAMES must be ≥1 and ≤ 2^FRAME_W, and every HOLD must be ≥1 and ≤ 2^HOLD_W.

## Timing
- Outputs are registered.
- Latency: an input change is reflected on the first SCEN edge after it.
- Reset (synchronous, overrides SCEN): anim_state=0, anim_frame=0, hold=0, anim_done=0, state_changed=0.
- Reset mid-animation: the next cycle shows IDLE, frame 0. No pulses are generated by reset.
- Simultaneous flags: priority decides. An interrupted one-shot (e.g. HIT preempting JUMP) restarts from frame 0 on its next entry.
- Same-state re-trigger (flag drops and rises between two SCEN ticks without being sampled) is invisible: the sequence continues.

## Structure
- Shared package anim_pkg holds the state encodings (S_IDLE, S_MOVE, S_JUMP, S_ATK1, S_HIT) and the state width constant.
- Sub-module anim_frame_counter contains the hold counter and frame counter.
  - Inputs: restart, tick, frames, hold, loop_mode.
  - Outputs: frame, done.
- Instantiate anim_frame_counter once. The top level muxes frames, hold and mode from the target state, since only one state is active at a time.
- Priority encode and the ATK clamp live in the top level.

## Test plan
- Reset then idle: SCEN every cycle, no flags.
  - anim_frame sequence 0,0,0,0,1,… (IDLE_HOLD=4).
  - anim_done pulses once per 16 ticks, on the wrap 3→0.
- Walk: move_active=1.
  - state_changed pulses on the first tick.
  - Frames 0,0,1,1,…,7,7,0 with anim_done on the 7→0 wrap.
- Hit one-shot: hitstun_active held for 20 ticks.
  - Frames go 0→3 (each held 3 ticks), then stay at 3.
  - anim_done pulses exactly once, on the tick the frame first reaches 3.
- Preemption: jump at frame 2, then hitstun_active=1.
  - Next tick: anim_state=5, anim_frame=0, state_changed=1.
  - Releasing hitstun with jump still high gives JUMP at frame 0.
- Attack clamp: attack_active=1, attack_frame=25.
  - anim_state=3, anim_frame=17, anim_done never asserted.
- SCEN gating and sync reset: SCEN low for 10 cycles, then reset asserted mid-walk.
  - During the gap, outputs are frozen and the pulses stay 0.
  - One cycle after reset, anim_state=0 and anim_frame=0.
